// File: rtl/kernel_launch_ctrl_pkg.sv
// Shared register map, CTRL/STATUS bit positions and launch FSM state type
// for the kernel launch controller.
package kernel_launch_pkg;

  localparam int unsigned REG_THREAD_COUNT = 32'd0;
  localparam int unsigned REG_CTRL         = 32'd1;
  localparam int unsigned REG_STATUS       = 32'd2;
  localparam int unsigned REG_ERR_CLR      = 32'd3;
  localparam int unsigned REG_CYC_LO       = 32'd4;
  localparam int unsigned REG_CYC_HI       = 32'd5;

  localparam int unsigned CTRL_LAUNCH    = 32'd0;
  localparam int unsigned CTRL_IRQ_CLEAR = 32'd1;
  localparam int unsigned CTRL_IRQ_EN    = 32'd2;

  localparam int unsigned STAT_BUSY     = 32'd0;
  localparam int unsigned STAT_DONE     = 32'd1;
  localparam int unsigned STAT_ERR_BUSY = 32'd2;
  localparam int unsigned STAT_ERR_ZERO = 32'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    CMPL = 2'd3
  } launch_state_t;

endpackage

// File: rtl/kernel_launch_ctrl_cycle_counter.sv
// Saturating launch cycle counter: cleared on the dispatcher reset cycle,
// counts while the kernel runs, holds its value otherwise.
module launch_cycle_counter #(
  parameter int CYC_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  output logic [CYC_BITS-1:0] count
);

  logic [CYC_BITS-1:0] r_count;

  // Clear has priority; stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {CYC_BITS{1'b0}};
    end else if (clear) begin
      r_count <= {CYC_BITS{1'b0}};
    end else if (enable && (r_count != {CYC_BITS{1'b1}})) begin
      r_count <= r_count + {{(CYC_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

// File: rtl/kernel_launch_ctrl.sv
// Host-facing kernel launch controller: host register file plus the
// dispatcher reset -> start -> wait-for-done sequencer. Define
// KERNEL_CYCLE_COUNT_EN to add the per-launch cycle counter at CYC_LO/HI.
module kernel_launch_ctrl
  import kernel_launch_pkg::*;
#(
  parameter int ADDR_BITS = 3,
  parameter int CYC_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_wr_en,
  input  logic [ADDR_BITS-1:0] host_wr_addr,
  input  logic [7:0]           host_wr_data,
  input  logic [ADDR_BITS-1:0] host_rd_addr,
  output logic [7:0]           host_rd_data,
  output logic [7:0]           thread_count,
  output logic                 dispatch_reset,
  output logic                 dispatch_start,
  input  logic                 dispatch_done,
  output logic                 irq
);

  launch_state_t r_state;
  logic [7:0]    r_thread_count;
  logic          r_dispatch_reset;
  logic          r_dispatch_start;
  logic          r_done;
  logic          r_err_zero;
  logic          r_err_busy;
  logic          r_irq_pending;
  logic          r_irq_en;

  logic          w_wr_tc;
  logic          w_wr_ctrl;
  logic          w_wr_errclr;
  logic          w_launch;
  logic          w_irq_clear;
  logic          w_busy;
  logic [7:0]    w_status;
  logic [7:0]    w_ctrl_rd;
  logic [CYC_BITS-1:0] w_cyc_count;
  logic [15:0]   w_cyc_rd;

  assign w_wr_tc     = host_wr_en && (host_wr_addr == ADDR_BITS'(REG_THREAD_COUNT));
  assign w_wr_ctrl   = host_wr_en && (host_wr_addr == ADDR_BITS'(REG_CTRL));
  assign w_wr_errclr = host_wr_en && (host_wr_addr == ADDR_BITS'(REG_ERR_CLR));
  assign w_launch    = w_wr_ctrl && host_wr_data[CTRL_LAUNCH];
  assign w_irq_clear = w_wr_ctrl && host_wr_data[CTRL_IRQ_CLEAR];
  assign w_busy      = (r_state != IDLE);

  // Launch FSM, host register writes and registered dispatcher outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_thread_count   <= 8'd0;
      r_dispatch_reset <= 1'b0;
      r_dispatch_start <= 1'b0;
      r_done           <= 1'b0;
      r_err_zero       <= 1'b0;
      r_err_busy       <= 1'b0;
      r_irq_pending    <= 1'b0;
      r_irq_en         <= 1'b0;
    end else begin
      r_dispatch_reset <= 1'b0;
      if (w_wr_ctrl) begin
        r_irq_en <= host_wr_data[CTRL_IRQ_EN];
      end
      if (w_wr_errclr) begin
        r_err_zero <= 1'b0;
        r_err_busy <= 1'b0;
      end
      if (w_irq_clear) begin
        r_irq_pending <= 1'b0;
      end
      if (w_wr_tc && !w_busy) begin
        r_thread_count <= host_wr_data;
      end
      if ((w_wr_tc || w_launch) && w_busy) begin
        r_err_busy <= 1'b1;
      end
      // dispatch_done is only honoured in RUN; in IDLE/RST it is stale.
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            if (r_thread_count != 8'd0) begin
              r_state          <= RST;
              r_done           <= 1'b0;
              r_dispatch_reset <= 1'b1;
            end else begin
              r_err_zero <= 1'b1;
            end
          end
        end
        RST: begin
          r_state          <= RUN;
          r_dispatch_start <= 1'b1;
        end
        RUN: begin
          if (dispatch_done) begin
            r_state          <= CMPL;
            r_dispatch_start <= 1'b0;
          end
        end
        CMPL: begin
          // Placed after the irq_clear update so a coincident clear loses.
          r_state       <= IDLE;
          r_done        <= 1'b1;
          r_irq_pending <= 1'b1;
        end
        default: begin
          r_state          <= IDLE;
          r_dispatch_start <= 1'b0;
        end
      endcase
    end
  end

`ifdef KERNEL_CYCLE_COUNT_EN
  launch_cycle_counter #(
    .CYC_BITS (CYC_BITS)
  ) u_cycle_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_state == RST),
    .enable (r_state == RUN),
    .count  (w_cyc_count)
  );
`else
  assign w_cyc_count = {CYC_BITS{1'b0}};
`endif

  assign w_cyc_rd = 16'(w_cyc_count);

  // Readback views of STATUS and CTRL.
  always_comb begin
    w_status                = 8'd0;
    w_status[STAT_BUSY]     = w_busy;
    w_status[STAT_DONE]     = r_done;
    w_status[STAT_ERR_BUSY] = r_err_busy;
    w_status[STAT_ERR_ZERO] = r_err_zero;
    w_ctrl_rd               = 8'd0;
    w_ctrl_rd[CTRL_IRQ_EN]  = r_irq_en;
  end

  // Combinational host read mux.
  always_comb begin
    host_rd_data = 8'd0;
    case (host_rd_addr)
      ADDR_BITS'(REG_THREAD_COUNT): host_rd_data = r_thread_count;
      ADDR_BITS'(REG_CTRL):         host_rd_data = w_ctrl_rd;
      ADDR_BITS'(REG_STATUS):       host_rd_data = w_status;
      ADDR_BITS'(REG_CYC_LO):       host_rd_data = w_cyc_rd[7:0];
      ADDR_BITS'(REG_CYC_HI):       host_rd_data = w_cyc_rd[15:8];
      default:                      host_rd_data = 8'd0;
    endcase
  end

  assign thread_count   = r_thread_count;
  assign dispatch_reset = r_dispatch_reset;
  assign dispatch_start = r_dispatch_start;
  assign irq            = r_irq_pending & r_irq_en;

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Directed self-checking bench for kernel_launch_ctrl; honours
// KERNEL_CYCLE_COUNT_EN for the expected cycle-count readback.
module tb_kernel_launch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       host_wr_en = 1'b0;
  logic [2:0] host_wr_addr = 3'd0;
  logic [7:0] host_wr_data = 8'd0;
  logic [2:0] host_rd_addr = 3'd0;
  logic [7:0] host_rd_data;
  logic [7:0] thread_count;
  logic       dispatch_reset;
  logic       dispatch_start;
  logic       dispatch_done = 1'b0;
  logic       irq;

  int n_checks = 0;
  int n_fails  = 0;

  kernel_launch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .host_wr_en     (host_wr_en),
    .host_wr_addr   (host_wr_addr),
    .host_wr_data   (host_wr_data),
    .host_rd_addr   (host_rd_addr),
    .host_rd_data   (host_rd_data),
    .thread_count   (thread_count),
    .dispatch_reset (dispatch_reset),
    .dispatch_start (dispatch_start),
    .dispatch_done  (dispatch_done),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    host_wr_en    = 1'b0;
    dispatch_done = 1'b0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic host_write(input logic [2:0] addr, input logic [7:0] data);
    host_wr_en   = 1'b1;
    host_wr_addr = addr;
    host_wr_data = data;
    tick();
    host_wr_en   = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] addr, output logic [7:0] data);
    host_rd_addr = addr;
    #1;
    data = host_rd_data;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    do_reset();
    n_checks++; if (dispatch_reset !== 1'b0) begin n_fails++; $display("FAIL rst_dispatch_reset: got %b want 0", dispatch_reset); end
    n_checks++; if (dispatch_start !== 1'b0) begin n_fails++; $display("FAIL rst_dispatch_start: got %b want 0", dispatch_start); end
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL rst_irq: got %b want 0", irq); end
    n_checks++; if (thread_count !== 8'h00) begin n_fails++; $display("FAIL rst_thread_count: got %h want 00", thread_count); end
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h00) begin n_fails++; $display("FAIL rst_status: got %h want 00", rd); end
    read_reg(3'd1, rd);
    n_checks++; if (rd !== 8'h00) begin n_fails++; $display("FAIL rst_ctrl: got %h want 00", rd); end
  endtask

  task automatic test_launch();
    logic [7:0]  rd;
    logic [7:0]  hi;
    logic [15:0] exp_cyc;
`ifdef KERNEL_CYCLE_COUNT_EN
    exp_cyc = 16'd6;
`else
    exp_cyc = 16'd0;
`endif
    do_reset();
    host_write(3'd0, 8'd10);
    host_write(3'd1, 8'h04);
    host_write(3'd1, 8'h05);
    n_checks++; if (dispatch_reset !== 1'b1) begin n_fails++; $display("FAIL t1_reset_pulse: got %b want 1", dispatch_reset); end
    n_checks++; if (dispatch_start !== 1'b0) begin n_fails++; $display("FAIL t1_start_in_rst: got %b want 0", dispatch_start); end
    n_checks++; if (thread_count !== 8'd10) begin n_fails++; $display("FAIL t1_thread_count: got %0d want 10", thread_count); end
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h01) begin n_fails++; $display("FAIL t1_status_rst: got %h want 01", rd); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (dispatch_start !== 1'b1) begin n_fails++; $display("FAIL t1_start_run%0d: got %b want 1", i, dispatch_start); end
      n_checks++; if (dispatch_reset !== 1'b0) begin n_fails++; $display("FAIL t1_reset_run%0d: got %b want 0", i, dispatch_reset); end
      if (i == 5) dispatch_done = 1'b1;
    end
    tick();
    n_checks++; if (dispatch_start !== 1'b0) begin n_fails++; $display("FAIL t1_start_cmpl: got %b want 0", dispatch_start); end
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL t1_irq_cmpl: got %b want 0", irq); end
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h01) begin n_fails++; $display("FAIL t1_status_cmpl: got %h want 01", rd); end
    tick();
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h02) begin n_fails++; $display("FAIL t1_status_done: got %h want 02", rd); end
    n_checks++; if (irq !== 1'b1) begin n_fails++; $display("FAIL t1_irq: got %b want 1", irq); end
    read_reg(3'd4, rd);
    read_reg(3'd5, hi);
    n_checks++; if ({hi, rd} !== exp_cyc) begin n_fails++; $display("FAIL t1_cycle_count: got %0d want %0d", {hi, rd}, exp_cyc); end
  endtask

  task automatic test_zero_tc();
    logic [7:0] rd;
    do_reset();
    host_write(3'd1, 8'h01);
    n_checks++; if (dispatch_reset !== 1'b0) begin n_fails++; $display("FAIL t2_no_reset: got %b want 0", dispatch_reset); end
    tick();
    n_checks++; if (dispatch_start !== 1'b0) begin n_fails++; $display("FAIL t2_no_start: got %b want 0", dispatch_start); end
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h08) begin n_fails++; $display("FAIL t2_status_err_zero: got %h want 08", rd); end
    host_write(3'd3, 8'h00);
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h00) begin n_fails++; $display("FAIL t2_status_errclr: got %h want 00", rd); end
  endtask

  task automatic test_busy_writes();
    logic [7:0] rd;
    do_reset();
    host_write(3'd0, 8'd10);
    host_write(3'd1, 8'h01);
    tick();
    tick();
    host_write(3'd0, 8'd20);
    n_checks++; if (thread_count !== 8'd10) begin n_fails++; $display("FAIL t3_thread_count: got %0d want 10", thread_count); end
    host_write(3'd1, 8'h01);
    n_checks++; if (dispatch_reset !== 1'b0) begin n_fails++; $display("FAIL t3_no_restart: got %b want 0", dispatch_reset); end
    n_checks++; if (dispatch_start !== 1'b1) begin n_fails++; $display("FAIL t3_start_held: got %b want 1", dispatch_start); end
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h05) begin n_fails++; $display("FAIL t3_status: got %h want 05", rd); end
    read_reg(3'd0, rd);
    n_checks++; if (rd !== 8'd10) begin n_fails++; $display("FAIL t3_tc_readback: got %0d want 10", rd); end
  endtask

  task automatic test_stale_done();
    logic [7:0] rd;
    do_reset();
    host_write(3'd0, 8'd5);
    dispatch_done = 1'b1;
    tick();
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h00) begin n_fails++; $display("FAIL t4_idle_ignores_done: got %h want 00", rd); end
    host_write(3'd1, 8'h01);
    n_checks++; if (dispatch_reset !== 1'b1) begin n_fails++; $display("FAIL t4_reset_pulse: got %b want 1", dispatch_reset); end
    tick();
    dispatch_done = 1'b0;
    n_checks++; if (dispatch_start !== 1'b1) begin n_fails++; $display("FAIL t4_start_after_rst: got %b want 1", dispatch_start); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (dispatch_start !== 1'b1) begin n_fails++; $display("FAIL t4_start_run%0d: got %b want 1", i, dispatch_start); end
    end
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h01) begin n_fails++; $display("FAIL t4_status_run: got %h want 01", rd); end
    dispatch_done = 1'b1;
    tick();
    n_checks++; if (dispatch_start !== 1'b0) begin n_fails++; $display("FAIL t4_start_drop: got %b want 0", dispatch_start); end
    tick();
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h02) begin n_fails++; $display("FAIL t4_status_done: got %h want 02", rd); end
  endtask

  task automatic test_irq();
    logic [7:0] rd;
    do_reset();
    host_write(3'd0, 8'd3);
    host_write(3'd1, 8'h05);
    tick();
    dispatch_done = 1'b1;
    tick();
    host_write(3'd1, 8'h06);
    n_checks++; if (irq !== 1'b1) begin n_fails++; $display("FAIL t5_set_wins: got %b want 1", irq); end
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h02) begin n_fails++; $display("FAIL t5_status: got %h want 02", rd); end
    read_reg(3'd1, rd);
    n_checks++; if (rd !== 8'h04) begin n_fails++; $display("FAIL t5_ctrl_read: got %h want 04", rd); end
    host_write(3'd1, 8'h06);
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL t5_irq_cleared: got %b want 0", irq); end
    host_write(3'd1, 8'h01);
    tick();
    tick();
    tick();
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL t5_irq_masked: got %b want 0", irq); end
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h02) begin n_fails++; $display("FAIL t5_status_masked: got %h want 02", rd); end
    host_write(3'd1, 8'h04);
    n_checks++; if (irq !== 1'b1) begin n_fails++; $display("FAIL t5_irq_unmasked: got %b want 1", irq); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] rd;
    do_reset();
    host_write(3'd0, 8'd7);
    host_write(3'd1, 8'h05);
    tick();
    dispatch_done = 1'b1;
    tick();
    tick();
    host_write(3'd1, 8'h05);
    tick();
    dispatch_done = 1'b0;
    n_checks++; if (dispatch_start !== 1'b1) begin n_fails++; $display("FAIL t6_start_before: got %b want 1", dispatch_start); end
    n_checks++; if (irq !== 1'b1) begin n_fails++; $display("FAIL t6_irq_before: got %b want 1", irq); end
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if (dispatch_start !== 1'b0) begin n_fails++; $display("FAIL t6_start_async: got %b want 0", dispatch_start); end
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL t6_irq_async: got %b want 0", irq); end
    #1;
    reset = 1'b0;
    read_reg(3'd2, rd);
    n_checks++; if (rd !== 8'h00) begin n_fails++; $display("FAIL t6_status: got %h want 00", rd); end
    host_write(3'd0, 8'd7);
    host_write(3'd1, 8'h01);
    n_checks++; if (dispatch_reset !== 1'b1) begin n_fails++; $display("FAIL t6_relaunch_reset: got %b want 1", dispatch_reset); end
    tick();
    n_checks++; if (dispatch_start !== 1'b1) begin n_fails++; $display("FAIL t6_relaunch_start: got %b want 1", dispatch_start); end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_zero_tc();
    test_busy_writes();
    test_stale_done();
    test_irq();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
